// File: rtl/zynet_pkg.sv
// Shared constants and types for the zynet parameter-load path: field widths,
// per-layer RAM geometry, layer enum, load FSM state encoding and write-address payload.
package zynet_pkg;

  localparam int unsigned MEM_WORD_SIZE     = 21;
  localparam int unsigned LAYER_SELECT_BITS = 2;
  localparam int unsigned RAM_SELECT_BITS   = 8;
  localparam int unsigned RAM_ADDRESS_BITS  = 9;
  localparam int unsigned W_ADDR_BITS       = LAYER_SELECT_BITS + RAM_SELECT_BITS + RAM_ADDRESS_BITS;

  localparam int unsigned N_LAYERS = 4;
  localparam int unsigned N_RAMS_TBL [N_LAYERS] = '{256, 256, 4, 10};
  localparam int unsigned DEPTH_TBL  [N_LAYERS] = '{33, 257, 256, 257};

  typedef enum logic [LAYER_SELECT_BITS-1:0] {
    L_CONV0,
    L_FC0,
    L_BN0,
    L_FC1
  } layer_e;

  typedef logic [1:0] load_state_t;
  localparam load_state_t ST_IDLE  = 2'd0;
  localparam load_state_t ST_LOAD  = 2'd1;
  localparam load_state_t ST_CHECK = 2'd2;
  localparam load_state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic [LAYER_SELECT_BITS-1:0] layer;
    logic [RAM_SELECT_BITS-1:0]   ram;
    logic [RAM_ADDRESS_BITS-1:0]  addr;
  } w_addr_t;

endpackage

// File: rtl/load_addr_counter.sv
// Nested addr/ram/layer counter walking every parameter RAM word in load order;
// limits are selected by the current layer and last_o flags the final word.
module load_addr_counter
  import zynet_pkg::*;
#(
  parameter int unsigned N_RAMS_L0 = N_RAMS_TBL[0],
  parameter int unsigned N_RAMS_L1 = N_RAMS_TBL[1],
  parameter int unsigned N_RAMS_L2 = N_RAMS_TBL[2],
  parameter int unsigned N_RAMS_L3 = N_RAMS_TBL[3],
  parameter int unsigned DEPTH_L0  = DEPTH_TBL[0],
  parameter int unsigned DEPTH_L1  = DEPTH_TBL[1],
  parameter int unsigned DEPTH_L2  = DEPTH_TBL[2],
  parameter int unsigned DEPTH_L3  = DEPTH_TBL[3]
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clear_i,
  input  logic                         step_i,
  output logic [LAYER_SELECT_BITS-1:0] layer_o,
  output logic [RAM_SELECT_BITS-1:0]   ram_o,
  output logic [RAM_ADDRESS_BITS-1:0]  addr_o,
  output logic                         last_o
);

  logic [LAYER_SELECT_BITS-1:0] layer_q, layer_d;
  logic [RAM_SELECT_BITS-1:0]   ram_q, ram_d;
  logic [RAM_ADDRESS_BITS-1:0]  addr_q, addr_d;
  logic [RAM_SELECT_BITS-1:0]   ram_max_c;
  logic [RAM_ADDRESS_BITS-1:0]  addr_max_c;
  logic                         last_layer_c;

  // Per-layer wrap limits
  always_comb begin
    ram_max_c  = RAM_SELECT_BITS'(N_RAMS_L0 - 1);
    addr_max_c = RAM_ADDRESS_BITS'(DEPTH_L0 - 1);
    case (layer_e'(layer_q))
      L_FC0: begin
        ram_max_c  = RAM_SELECT_BITS'(N_RAMS_L1 - 1);
        addr_max_c = RAM_ADDRESS_BITS'(DEPTH_L1 - 1);
      end
      L_BN0: begin
        ram_max_c  = RAM_SELECT_BITS'(N_RAMS_L2 - 1);
        addr_max_c = RAM_ADDRESS_BITS'(DEPTH_L2 - 1);
      end
      L_FC1: begin
        ram_max_c  = RAM_SELECT_BITS'(N_RAMS_L3 - 1);
        addr_max_c = RAM_ADDRESS_BITS'(DEPTH_L3 - 1);
      end
      default: ;
    endcase
  end

  assign last_layer_c = (layer_e'(layer_q) == L_FC1);
  assign last_o       = last_layer_c && (ram_q == ram_max_c) && (addr_q == addr_max_c);

  always_comb begin
    layer_d = layer_q;
    ram_d   = ram_q;
    addr_d  = addr_q;
    if (clear_i) begin
      layer_d = '0;
      ram_d   = '0;
      addr_d  = '0;
    end else if (step_i) begin
      if (addr_q == addr_max_c) begin
        addr_d = '0;
        if (ram_q == ram_max_c) begin
          ram_d   = '0;
          layer_d = last_layer_c ? '0 : layer_q + LAYER_SELECT_BITS'(1);
        end else begin
          ram_d = ram_q + RAM_SELECT_BITS'(1);
        end
      end else begin
        addr_d = addr_q + RAM_ADDRESS_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      layer_q <= '0;
      ram_q   <= '0;
      addr_q  <= '0;
    end else begin
      layer_q <= layer_d;
      ram_q   <= ram_d;
      addr_q  <= addr_d;
    end
  end

  assign layer_o = layer_q;
  assign ram_o   = ram_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/weight_load_ctrl.sv
// One-shot loader streaming every layer parameter RAM word onto the {layer,ram,addr} write bus
// and gating net start until loaded. WLOAD_CHECKSUM_EN adds a trailing checksum word check.
module weight_load_ctrl
  import zynet_pkg::*;
#(
  parameter int unsigned N_RAMS_L0 = N_RAMS_TBL[0],
  parameter int unsigned N_RAMS_L1 = N_RAMS_TBL[1],
  parameter int unsigned N_RAMS_L2 = N_RAMS_TBL[2],
  parameter int unsigned N_RAMS_L3 = N_RAMS_TBL[3],
  parameter int unsigned DEPTH_L0  = DEPTH_TBL[0],
  parameter int unsigned DEPTH_L1  = DEPTH_TBL[1],
  parameter int unsigned DEPTH_L2  = DEPTH_TBL[2],
  parameter int unsigned DEPTH_L3  = DEPTH_TBL[3]
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     load_start_i,
  input  logic [MEM_WORD_SIZE-1:0] data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     w_en_o,
  output logic [W_ADDR_BITS-1:0]   w_addr_o,
  output logic [MEM_WORD_SIZE-1:0] w_data_o,
  input  logic                     net_start_i,
  output logic                     net_start_o,
  output logic                     busy_o,
  output logic                     loaded_o,
  output logic                     err_o
);

  load_state_t              state_q, state_d;
  logic                     loaded_q, loaded_d;
  logic                     w_en_q, w_en_d;
  w_addr_t                  w_addr_q, w_addr_d;
  logic [MEM_WORD_SIZE-1:0] w_data_q, w_data_d;

  logic                         xfer_c, step_c, clear_c, last_c;
  logic [LAYER_SELECT_BITS-1:0] layer_c;
  logic [RAM_SELECT_BITS-1:0]   ram_c;
  logic [RAM_ADDRESS_BITS-1:0]  addr_c;

`ifdef WLOAD_CHECKSUM_EN
  logic [MEM_WORD_SIZE-1:0] sum_q, sum_d;
  logic                     err_q, err_d;
  logic                     sum_ok_c;
`endif

  assign ready_o = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign busy_o  = ready_o;
  assign xfer_c  = valid_i && ready_o;
  assign step_c  = xfer_c && (state_q == ST_LOAD);
  assign clear_c = load_start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  load_addr_counter #(
    .N_RAMS_L0(N_RAMS_L0), .N_RAMS_L1(N_RAMS_L1), .N_RAMS_L2(N_RAMS_L2), .N_RAMS_L3(N_RAMS_L3),
    .DEPTH_L0 (DEPTH_L0),  .DEPTH_L1 (DEPTH_L1),  .DEPTH_L2 (DEPTH_L2),  .DEPTH_L3 (DEPTH_L3)
  ) u_addr_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_c),
    .step_i  (step_c),
    .layer_o (layer_c),
    .ram_o   (ram_c),
    .addr_o  (addr_c),
    .last_o  (last_c)
  );

`ifdef WLOAD_CHECKSUM_EN
  // Running sum of accepted parameter words; error stays set until the next load or reset
  assign sum_ok_c = (data_i == sum_q);

  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (clear_c) begin
      sum_d = '0;
      err_d = 1'b0;
    end else if (step_c) begin
      sum_d = sum_q + data_i;
    end else if (xfer_c && (state_q == ST_CHECK) && !sum_ok_c) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (step_c) begin
      w_en_d   = 1'b1;
      w_addr_d = '{layer: layer_c, ram: ram_c, addr: addr_c};
      w_data_d = data_i;
    end
    case (state_q)
      ST_IDLE: if (load_start_i) state_d = ST_LOAD;
      ST_LOAD: begin
        if (step_c && last_c) begin
`ifdef WLOAD_CHECKSUM_EN
          state_d  = ST_CHECK;
`else
          state_d  = ST_DONE;
          loaded_d = 1'b1;
`endif
        end
      end
`ifdef WLOAD_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer_c) begin
          state_d  = ST_DONE;
          loaded_d = sum_ok_c;
        end
      end
`endif
      ST_DONE: begin
        if (load_start_i) begin
          state_d  = ST_LOAD;
          loaded_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      loaded_q <= 1'b0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign w_en_o      = w_en_q;
  assign w_addr_o    = w_addr_q;
  assign w_data_o    = w_data_q;
  assign loaded_o    = loaded_q;
  assign net_start_o = net_start_i && loaded_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl with a reduced 4 x 2 RAMs x 3 words geometry (24 words).
// Honours WLOAD_CHECKSUM_EN when defined for the whole build.
`timescale 1ns/1ps
module tb_weight_load_ctrl;
  import zynet_pkg::*;

  localparam int NR     = 2;
  localparam int DP     = 3;
  localparam int NWORDS = 4 * NR * DP;

  logic                     clk = 1'b0;
  logic                     reset_i;
  logic                     load_start_i;
  logic [MEM_WORD_SIZE-1:0] data_i;
  logic                     valid_i;
  logic                     ready_o;
  logic                     w_en_o;
  logic [W_ADDR_BITS-1:0]   w_addr_o;
  logic [MEM_WORD_SIZE-1:0] w_data_o;
  logic                     net_start_i;
  logic                     net_start_o;
  logic                     busy_o;
  logic                     loaded_o;
  logic                     err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  weight_load_ctrl #(
    .N_RAMS_L0(NR), .N_RAMS_L1(NR), .N_RAMS_L2(NR), .N_RAMS_L3(NR),
    .DEPTH_L0 (DP), .DEPTH_L1 (DP), .DEPTH_L2 (DP), .DEPTH_L3 (DP)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .load_start_i (load_start_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .w_en_o       (w_en_o),
    .w_addr_o     (w_addr_o),
    .w_data_o     (w_data_o),
    .net_start_i  (net_start_i),
    .net_start_o  (net_start_o),
    .busy_o       (busy_o),
    .loaded_o     (loaded_o),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word k lands at layer k/6, ram (k%6)/3, addr k%3
  function automatic logic [W_ADDR_BITS-1:0] exp_addr(input int k);
    logic [LAYER_SELECT_BITS-1:0] l;
    logic [RAM_SELECT_BITS-1:0]   r;
    logic [RAM_ADDRESS_BITS-1:0]  a;
    l = LAYER_SELECT_BITS'(k / (NR * DP));
    r = RAM_SELECT_BITS'((k % (NR * DP)) / DP);
    a = RAM_ADDRESS_BITS'(k % DP);
    return {l, r, a};
  endfunction

  task automatic stream(input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        valid_i = 1'b0;
        tick();
        chk("gap_wen", 32'(w_en_o), 32'd0);
      end
      valid_i = 1'b1;
      data_i  = MEM_WORD_SIZE'(k + 1);
      tick();
      chk($sformatf("wen[%0d]", k), 32'(w_en_o), 32'd1);
      chk($sformatf("waddr[%0d]", k), 32'(w_addr_o), 32'(exp_addr(k)));
      chk($sformatf("wdata[%0d]", k), 32'(w_data_o), 32'(k + 1));
      if (k < n - 1) chk($sformatf("loaded_mid[%0d]", k), 32'(loaded_o), 32'd0);
    end
    valid_i = 1'b0;
  endtask

  task automatic finish_load(input int trailer, input bit exp_ok);
`ifdef WLOAD_CHECKSUM_EN
    chk("check_busy", 32'(busy_o), 32'd1);
    chk("check_loaded_pre", 32'(loaded_o), 32'd0);
    valid_i = 1'b1;
    data_i  = MEM_WORD_SIZE'(trailer);
    tick();
    valid_i = 1'b0;
    chk("check_wen", 32'(w_en_o), 32'd0);
    chk("loaded", 32'(loaded_o), 32'(exp_ok));
    chk("err", 32'(err_o), 32'(!exp_ok));
`else
    chk("loaded", 32'(loaded_o), 32'd1);
    chk("err", 32'(err_o), 32'd0);
    chk("trailer_unused", 32'(trailer), 32'd300);
`endif
    chk("done_busy", 32'(busy_o), 32'd0);
    net_start_i = 1'b1;
    #1;
    chk("net_start", 32'(net_start_o), 32'(exp_ok));
    net_start_i = 1'b0;
    valid_i = 1'b1;
    data_i  = MEM_WORD_SIZE'(99);
    tick();
    valid_i = 1'b0;
    chk("done_ready", 32'(ready_o), 32'd0);
    chk("done_wen", 32'(w_en_o), 32'd0);
  endtask

  task automatic pulse_start();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
  endtask

  initial begin
    reset_i      = 1'b1;
    load_start_i = 1'b0;
    valid_i      = 1'b0;
    data_i       = '0;
    net_start_i  = 1'b0;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();

    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_wen", 32'(w_en_o), 32'd0);
    chk("rst_waddr", 32'(w_addr_o), 32'd0);
    chk("rst_wdata", 32'(w_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_loaded", 32'(loaded_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    net_start_i = 1'b1;
    #1;
    chk("rst_net_start", 32'(net_start_o), 32'd0);
    net_start_i = 1'b0;

    // Continuous load
    pulse_start();
    chk("load_busy", 32'(busy_o), 32'd1);
    chk("load_ready", 32'(ready_o), 32'd1);
    chk("load_wen0", 32'(w_en_o), 32'd0);
    stream(NWORDS, 1'b0);
    finish_load(300, 1'b1);

    // Restart from DONE with valid toggling
    pulse_start();
    chk("restart_loaded", 32'(loaded_o), 32'd0);
    chk("restart_busy", 32'(busy_o), 32'd1);
    stream(NWORDS, 1'b1);
    finish_load(300, 1'b1);

    // Reset part-way through a load, then a fresh load
    pulse_start();
    stream(10, 1'b0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("midrst_loaded", 32'(loaded_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_ready", 32'(ready_o), 32'd0);
    chk("midrst_wen", 32'(w_en_o), 32'd0);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("midrst_wen_idle", 32'(w_en_o), 32'd0);
    pulse_start();
    stream(NWORDS, 1'b0);
    finish_load(300, 1'b1);

`ifdef WLOAD_CHECKSUM_EN
    // Wrong checksum trailer, then restart clears the error
    pulse_start();
    stream(NWORDS, 1'b0);
    finish_load(301, 1'b0);
    pulse_start();
    chk("err_cleared", 32'(err_o), 32'd0);
    chk("err_restart_busy", 32'(busy_o), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
